// File: rtl/gating_pkg.sv
// Shared widths and state encoding for the gating module's arithmetic pipeline.
package gating_pkg;

  localparam int FP16_W         = 16;
  localparam int TBUF_ADDR_W    = 8;
  localparam int TBUF_DATA_W    = 64;
  localparam int LANES_PER_WORD = 4;
  localparam int VEC_LEN_MAX    = 16;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DRAIN,
    DONE
  } wb_state_t;

endpackage

// File: rtl/wb_word_fifo.sv
// Show-ahead FIFO of packed write-back entries; head is valid whenever empty is low.
module wb_word_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         one_left
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [PW:0]   count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full_reg;
  assign do_pop  = pop && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Flags are registered from the next count, so a full FIFO that pops still reads full this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == (PW+1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head     = mem[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign one_left = (count_reg == (PW+1)'(1));

endmodule

// File: rtl/tbuf_wb_packer.sv
// Packs the serial FP16 result stream into token-buffer words and writes them from a base address.
// Optional per-lane write mask enabled by defining TBUF_WB_LANE_MASK_EN.
module tbuf_wb_packer
  import gating_pkg::*;
#(
  parameter int DATA_W     = FP16_W,
  parameter int LANES      = LANES_PER_WORD,
  parameter int ADDR_W     = TBUF_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [ADDR_W-1:0]       cfg_base_addr,
  input  logic [4:0]              cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    tbuf_wr_en,
  input  logic                    tbuf_wr_ready,
  output logic [ADDR_W-1:0]       tbuf_wr_addr,
  output logic [DATA_W*LANES-1:0] tbuf_wr_data,
`ifdef TBUF_WB_LANE_MASK_EN
  output logic [LANES-1:0]        tbuf_wr_mask,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam int WORD_W = DATA_W * LANES;
  localparam int LW     = $clog2(LANES);
  localparam int LEN_W  = 5;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(VEC_LEN_MAX);
`ifdef TBUF_WB_LANE_MASK_EN
  localparam int ENT_W = ADDR_W + WORD_W + LANES;
`else
  localparam int ENT_W = ADDR_W + WORD_W;
`endif

  wb_state_t         state_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  elem_cnt_reg;
  logic [LEN_W-1:0]  cfg_len_clamped;
  logic [LW-1:0]     lane_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] pack_reg [LANES];
  logic              accept;
  logic              last_elem;
  logic              word_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_one;
  logic [WORD_W-1:0] word_data;
  logic [ENT_W-1:0]  fifo_in;
  logic [ENT_W-1:0]  fifo_head;
`ifdef TBUF_WB_LANE_MASK_EN
  logic [LANES-1:0]  word_mask;
`endif

  assign cfg_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign in_ready  = (state_reg == PACK) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign last_elem = ((elem_cnt_reg + 1'b1) == len_reg);
  assign word_push = accept && ((lane_cnt_reg == LW'(LANES - 1)) || last_elem);

  // Lanes below the current one come from the pack register, the current lane bypasses
  // straight from the input, and lanes above it are padding.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LW-1:0] LANE_IDX = LW'(gi);
      assign word_data[gi*DATA_W +: DATA_W] =
        (LANE_IDX < lane_cnt_reg)  ? pack_reg[gi] :
        (LANE_IDX == lane_cnt_reg) ? in_data : '0;
`ifdef TBUF_WB_LANE_MASK_EN
      assign word_mask[gi] = (LANE_IDX <= lane_cnt_reg);
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) pack_reg[lane_cnt_reg] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      elem_cnt_reg <= '0;
      lane_cnt_reg <= '0;
      addr_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cfg_valid) begin
            addr_reg     <= cfg_base_addr;
            len_reg      <= cfg_len_clamped;
            elem_cnt_reg <= '0;
            lane_cnt_reg <= '0;
            state_reg    <= (cfg_len_clamped == '0) ? DONE : PACK;
          end
        end
        PACK: begin
          if (accept) begin
            elem_cnt_reg <= elem_cnt_reg + 1'b1;
            lane_cnt_reg <= lane_cnt_reg + 1'b1;
            if (word_push) addr_reg <= addr_reg + 1'b1;
            if (last_elem) state_reg <= DRAIN;
          end
        end
        // Leave as the final write handshakes so done trails it by exactly one cycle.
        DRAIN: begin
          if (fifo_empty || (fifo_one && fifo_pop)) state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef TBUF_WB_LANE_MASK_EN
  assign fifo_in = {addr_reg, word_data, word_mask};
`else
  assign fifo_in = {addr_reg, word_data};
`endif

  wb_word_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .one_left  (fifo_one)
  );

  assign tbuf_wr_en   = !fifo_empty;
  assign fifo_pop     = tbuf_wr_en && tbuf_wr_ready;
  assign tbuf_wr_addr = fifo_empty ? '0 : fifo_head[ENT_W-1 -: ADDR_W];
  assign tbuf_wr_data = fifo_empty ? '0 : fifo_head[ENT_W-ADDR_W-1 -: WORD_W];
`ifdef TBUF_WB_LANE_MASK_EN
  assign tbuf_wr_mask = fifo_empty ? '0 : fifo_head[LANES-1:0];
`endif

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_tbuf_wb_packer.sv
// Scoreboard bench for tbuf_wb_packer: directed jobs push expected writes, a monitor checks them.
module tb_tbuf_wb_packer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [7:0]  cfg_base_addr;
  logic [4:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        tbuf_wr_en;
  logic        tbuf_wr_ready;
  logic [7:0]  tbuf_wr_addr;
  logic [63:0] tbuf_wr_data;
`ifdef TBUF_WB_LANE_MASK_EN
  logic [3:0]  tbuf_wr_mask;
`endif
  logic        busy;
  logic        done;

  tbuf_wb_packer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_base_addr (cfg_base_addr),
    .cfg_len       (cfg_len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .tbuf_wr_en    (tbuf_wr_en),
    .tbuf_wr_ready (tbuf_wr_ready),
    .tbuf_wr_addr  (tbuf_wr_addr),
    .tbuf_wr_data  (tbuf_wr_data),
`ifdef TBUF_WB_LANE_MASK_EN
    .tbuf_wr_mask  (tbuf_wr_mask),
`endif
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          done_count = 0;
  int          accepted = 0;
  int          last_wr_cycle = 0;
  int          cfg_cycle = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  addr_prev;
  logic [63:0] data_prev;
  logic [63:0] wd [4];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_word(input logic [7:0] a, input logic [63:0] d, input logic [3:0] m);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.mask = m;
    sb.push_back(e);
  endtask

  // Monitor: hold-stability under backpressure and in-order write scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_en", tbuf_wr_en, 1'b1);
        check("hold_addr", tbuf_wr_addr, addr_prev);
        check("hold_data", tbuf_wr_data, data_prev);
      end
      if (tbuf_wr_en && tbuf_wr_ready) begin
        exp_t e;
        wr_count++;
        last_wr_cycle = cyc;
        $display("wr cyc=%0d addr=%02h data=%016h", cyc, tbuf_wr_addr, tbuf_wr_data);
        check("wr_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", tbuf_wr_addr, e.addr);
          check("wr_data", tbuf_wr_data, e.data);
`ifdef TBUF_WB_LANE_MASK_EN
          check("wr_mask", tbuf_wr_mask, e.mask);
`endif
        end
      end
      if (done) done_count++;
      if (in_valid && in_ready) accepted++;
      stall_prev = tbuf_wr_en && !tbuf_wr_ready;
      addr_prev  = tbuf_wr_addr;
      data_prev  = tbuf_wr_data;
    end
  end

  task automatic start_job(input logic [7:0] base, input logic [4:0] len);
    cfg_base_addr = base;
    cfg_len       = len;
    cfg_valid     = 1'b1;
    cfg_cycle     = cyc;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Presents elements 1..n, each held until accepted.
  task automatic feed(input int n);
    for (int i = 1; i <= n; i++) begin
      logic acc;
      int   guard;
      acc   = 1'b0;
      guard = 0;
      in_data  = 16'(i);
      in_valid = 1'b1;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = in_ready;
        guard++;
      end
      if (!acc) check("in_accept_timeout", acc, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(output int dcyc);
    logic found;
    int   guard;
    found = 1'b0;
    guard = 0;
    dcyc  = -1;
    while (!found && guard < 200) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        dcyc  = cyc;
      end
      guard++;
    end
    check("done_seen", found, 1'b1);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    int d0;
    int a0;
    int dcyc;

    wd[0] = 64'h0004_0003_0002_0001;
    wd[1] = 64'h0008_0007_0006_0005;
    wd[2] = 64'h000C_000B_000A_0009;
    wd[3] = 64'h0010_000F_000E_000D;

    rst = 1'b1; cfg_valid = 1'b0; cfg_base_addr = '0; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; tbuf_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wr_en", tbuf_wr_en, 1'b0);
    check("rst_wr_addr", tbuf_wr_addr, 8'h00);
    check("rst_wr_data", tbuf_wr_data, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic job
    w0 = wr_count; d0 = done_count;
    start_job(8'h10, 5'd16);
    check("basic_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) expect_word(8'h10 + 8'(i), wd[i], 4'hF);
    feed(16);
    wait_done(dcyc);
    check("basic_writes", wr_count - w0, 4);
    check("basic_done_lat", dcyc, last_wr_cycle + 1);
    check("basic_done_cnt", done_count - d0, 1);
    check("basic_sb_empty", sb.size(), 0);

    // Partial final word
    w0 = wr_count;
    start_job(8'h20, 5'd6);
    expect_word(8'h20, wd[0], 4'hF);
    expect_word(8'h21, 64'h0000_0000_0006_0005, 4'b0011);
    feed(6);
    wait_done(dcyc);
    check("partial_writes", wr_count - w0, 2);
    check("partial_done_lat", dcyc, last_wr_cycle + 1);

    // Address wrap plus an ignored start while busy
    w0 = wr_count; d0 = done_count;
    start_job(8'hFE, 5'd16);
    expect_word(8'hFE, wd[0], 4'hF);
    expect_word(8'hFF, wd[1], 4'hF);
    expect_word(8'h00, wd[2], 4'hF);
    expect_word(8'h01, wd[3], 4'hF);
    cfg_base_addr = 8'h80; cfg_len = 5'd4; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    feed(16);
    wait_done(dcyc);
    check("wrap_writes", wr_count - w0, 4);
    check("wrap_done_cnt", done_count - d0, 1);
    check("wrap_sb_empty", sb.size(), 0);

    // Backpressure: token buffer stalls for the first 20 cycles
    w0 = wr_count;
    tbuf_wr_ready = 1'b0;
    start_job(8'h30, 5'd16);
    for (int i = 0; i < 4; i++) expect_word(8'h30 + 8'(i), wd[i], 4'hF);
    a0 = accepted;
    fork
      feed(16);
      begin
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", accepted - a0, 8);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_no_writes", wr_count - w0, 0);
        @(posedge clk); #1;
        tbuf_wr_ready = 1'b1;
      end
    join
    wait_done(dcyc);
    check("bp_writes", wr_count - w0, 4);
    check("bp_done_lat", dcyc, last_wr_cycle + 1);
    check("bp_sb_empty", sb.size(), 0);

    // Empty job
    w0 = wr_count;
    start_job(8'h50, 5'd0);
    wait_done(dcyc);
    check("empty_done_lat", dcyc, cfg_cycle + 1);
    check("empty_writes", wr_count - w0, 0);

    // Length above the maximum clamps to 16
    w0 = wr_count;
    start_job(8'h60, 5'd31);
    for (int i = 0; i < 4; i++) expect_word(8'h60 + 8'(i), wd[i], 4'hF);
    feed(16);
    wait_done(dcyc);
    check("clamp_writes", wr_count - w0, 4);

    // Reset mid-job after 5 elements
    w0 = wr_count; d0 = done_count;
    start_job(8'h70, 5'd16);
    expect_word(8'h70, wd[0], 4'hF);
    feed(5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_wr_en", tbuf_wr_en, 1'b0);
    check("mid_rst_wr_addr", tbuf_wr_addr, 8'h00);
    check("mid_rst_wr_data", tbuf_wr_data, 64'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("mid_rst_no_done", done_count - d0, 0);
    check("mid_rst_writes", wr_count - w0, 1);
    check("mid_rst_sb_empty", sb.size(), 0);

    w0 = wr_count;
    start_job(8'h40, 5'd4);
    expect_word(8'h40, wd[0], 4'hF);
    feed(4);
    wait_done(dcyc);
    check("post_rst_writes", wr_count - w0, 1);
    check("post_rst_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tbuf_wb_packer.md
Name: tbuf_wb_packer

Overview:
- Downstream write-back stage of the gating module's arithmetic pipeline.
- Accepts the serial FP16 result stream (one element per cycle), packs 4 elements into each 64-bit token-buffer word, and issues sequential writes from a configured base address.
- A small word FIFO absorbs token-buffer backpressure.
- Used for ACT outputs and AGG psum write-back; one configured vector is at most 16 elements.

Parameters:
- DATA_W, 16, element width (FP16)
- LANES, 4, elements per token-buffer word
- ADDR_W, 8, token-buffer address width
- FIFO_DEPTH, 2, packed-word FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  start pulse, sampled only in IDLE
- cfg_base_addr  in  ADDR_W  first word address
- cfg_len  in  5  element count; 0 = empty job; values >16 clamp to 16
- in_valid  in  1  element valid from arithmetic pipeline
- in_ready  out  1  element accepted when in_valid && in_ready
- in_data  in  DATA_W  FP16 element
- tbuf_wr_en  out  1  write request (FIFO head valid)
- tbuf_wr_ready  in  1  token buffer accepts; write fires on tbuf_wr_en && tbuf_wr_ready
- tbuf_wr_addr  out  ADDR_W  write address
- tbuf_wr_data  out  DATA_W*LANES  packed word; lane i at bits [16i+15:16i]
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset values: every output is 0. The FIFO, lane counter, element counter and address register are cleared and the state goes to IDLE. Reset mid-job aborts the job: no further writes, and done is not pulsed.
- States:
  - IDLE --cfg_valid--> PACK. If the clamped length is 0, go to DONE instead.
  - PACK --last element accepted--> DRAIN.
  - DRAIN --FIFO empty--> DONE.
  - DONE --> IDLE after 1 cycle. done=1 only in DONE.
- cfg_valid while busy is ignored. cfg_base_addr and cfg_len are latched on the cycle cfg_valid is accepted.
- in_ready = (state==PACK) && !fifo_full. Input outside PACK is never accepted.
- Element packing:
  - The element at position n goes to lane n mod 4 of a pack register.
  - A word is pushed into the FIFO when lane 3 is filled, or when the final element is accepted.
  - Unfilled lanes of the final word are zero-padded.
- Word address = latched base + word index, modulo 2^ADDR_W (wraps 0xFF->0x00).
- Latency: an element that completes a word is accepted in cycle N; tbuf_wr_en/addr/data present that word in cycle N+1 (show-ahead FIFO, registered outputs).
- tbuf_wr_addr and tbuf_wr_data are held stable while tbuf_wr_en && !tbuf_wr_ready.
- The FIFO may push and pop in the same cycle. When it is full and pops, it still reports full in that cycle: in_ready uses the registered full flag.
- Words written per job = ceil(len/4). done follows the last write handshake by exactly 1 cycle (DRAIN->DONE).

Optional Feature:
- Macro: TBUF_WB_LANE_MASK_EN.
- When defined:
  - Adds output tbuf_wr_mask [LANES-1:0], one bit per filled lane, stored in the FIFO alongside each word.
  - Padded lanes have mask 0 and data 0.
  - Reset value is 0.
- When undefined: the port is absent and padded lanes are simply zero.

Decomposition:
- Package gating_pkg holds:
  - FP16_W=16, TBUF_ADDR_W=8, TBUF_DATA_W=64, LANES_PER_WORD=4, VEC_LEN_MAX=16
  - wb_state_t enum {IDLE, PACK, DRAIN, DONE}
- One sub-module: wb_word_fifo.
  - Synchronous show-ahead FIFO of {addr, data[, mask]}, depth FIFO_DEPTH.
  - Provides full/empty flags and uses the same clk/rst.

Test Plan:
- Basic job:
  - Stimulus: base=0x10, len=16, in_data=0x0001..0x0010 back-to-back, wr_ready=1.
  - Required: 4 writes to addr 0x10..0x13; first data 0x0004_0003_0002_0001, last 0x0010_000F_000E_000D; done 1 cycle after the last write.
- Partial final word:
  - Stimulus: len=6, data 0x0001..0x0006.
  - Required: 2 writes; second word 0x0000_0000_0006_0005 (mask 4'b0011 if enabled).
- Address wrap:
  - Stimulus: base=0xFE, len=16.
  - Required: addresses 0xFE, 0xFF, 0x00, 0x01.
- Backpressure:
  - Stimulus: wr_ready=0 for the first 20 cycles, len=16, in_valid held high.
  - Required: in_ready drops after 8 accepted elements; tbuf_wr_addr/data stay stable; all 4 words are written in order once ready=1; no loss or duplication.
- Empty job and busy start:
  - Stimulus: len=0.
  - Required: no tbuf_wr_en; done asserted 1 cycle after cfg_valid.
  - Stimulus: a second cfg_valid during PACK.
  - Required: ignored; word count is unchanged.
- Reset mid-job:
  - Stimulus: rst after 5 elements.
  - Required: all outputs 0 the next cycle; no done; a following job with len=4 writes exactly 1 word.
